// File: rtl/dff_serial_pkg.sv
// Shared types and sizing helpers for the dff_serial_tx transmitter.
package dff_serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bits per frame: data bits plus the optional parity bit.
  function automatic int flen(input int width, input int parity);
    return width + ((parity != 0) ? 1 : 0);
  endfunction

  // Down-counter width for a frame; never narrower than one bit.
  function automatic int cnt_width(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/dff_piso_shreg.sv
// Parallel-load, left-shift register; the MSB is the serial output.
module dff_piso_shreg #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           shift_i,
  input  logic [WIDTH:0] data_i,
  output logic           msb_o
);

  logic [WIDTH:0] sreg_q;
  logic [WIDTH:0] sreg_d;

  // Load wins over shift; zeros enter from the LSB end.
  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = data_i;
    end else if (shift_i) begin
      sreg_d = {sreg_q[WIDTH-1:0], 1'b0};
    end
  end

  // NOTE: the data register is reset as well, so no stale bits survive an aborted frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign msb_o = sreg_q[WIDTH];

endmodule

// File: rtl/dff_serial_tx.sv
// Valid/ready parallel-in, MSB-first serial-out transmitter with frame strobe,
// optional even parity and a registered end-of-frame pulse.
module dff_serial_tx
  import dff_serial_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int PARITY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sd,
  output logic             sframe,
  output logic             done
);

  localparam int FLEN  = flen(WIDTH, PARITY);
  localparam int CNT_W = cnt_width(FLEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             load, shift;
  logic             par_bit;
  logic             msb;

  // With PARITY=0 the extra LSB is a don't-care zero that never reaches sd.
  assign par_bit = (PARITY != 0) ? ^load_data : 1'b0;

  dff_piso_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  ({load_data, par_bit}),
    .msb_o   (msb)
  );

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    load_ready = (state_q == IDLE);
    sframe     = (state_q == SHIFT);
    sd         = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          load    = 1'b1;
          cnt_d   = CNT_W'(FLEN - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sd    = msb;
        shift = 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_dff_serial_tx.sv
// Directed, scoreboard-based bench: one PARITY=0 and one PARITY=1 transmitter.
module tb_dff_serial_tx;

  localparam int WIDTH = 8;
  localparam int FLEN0 = WIDTH;
  localparam int FLEN1 = WIDTH + 1;

  logic             clk;
  logic             rst;
  logic             lv0, lv1;
  logic [WIDTH-1:0] ld0, ld1;
  logic             rdy0, rdy1;
  logic             sd0, sd1;
  logic             sf0, sf1;
  logic             dn0, dn1;

  int errors = 0;
  int checks = 0;

  bit q0[$];
  bit q1[$];

  dff_serial_tx #(.WIDTH(WIDTH), .PARITY(0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .load_valid (lv0),
    .load_data  (ld0),
    .load_ready (rdy0),
    .sd         (sd0),
    .sframe     (sf0),
    .done       (dn0)
  );

  dff_serial_tx #(.WIDTH(WIDTH), .PARITY(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .load_valid (lv1),
    .load_data  (ld1),
    .load_ready (rdy1),
    .sd         (sd1),
    .sframe     (sf1),
    .done       (dn1)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every bit seen while sframe=1 must be the next one queued.
  always @(negedge clk) begin
    if (!rst) begin
      if (sf0) begin
        if (q0.size() == 0) check("dut0_extra_bit", 1, 0);
        else check("dut0_sd", sd0, q0.pop_front());
      end else begin
        check("dut0_sd_idle", sd0, 0);
      end
      if (sf1) begin
        if (q1.size() == 0) check("dut1_extra_bit", 1, 0);
        else check("dut1_sd", sd1, q1.pop_front());
      end else begin
        check("dut1_sd_idle", sd1, 0);
      end
    end
  end

  task automatic push_word(input bit which, input logic [WIDTH-1:0] d);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (which) q1.push_back(d[i]);
      else       q0.push_back(d[i]);
    end
    if (which) q1.push_back(^d);
  endtask

  // Called just after a negedge while the target is idle.
  task automatic send(input bit which, input logic [WIDTH-1:0] d);
    push_word(which, d);
    if (which) begin lv1 = 1'b1; ld1 = d; end
    else       begin lv0 = 1'b1; ld0 = d; end
    @(posedge clk);
    #1;
    if (which) lv1 = 1'b0;
    else       lv0 = 1'b0;
  endtask

  task automatic expect_frame(input bit which);
    int n;
    n = which ? FLEN1 : FLEN0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("frame_sframe", which ? sf1 : sf0, 1);
      check("frame_ready",  which ? rdy1 : rdy0, 0);
      check("frame_done",   which ? dn1 : dn0, 0);
    end
    @(negedge clk);
    check("end_done",   which ? dn1 : dn0, 1);
    check("end_ready",  which ? rdy1 : rdy0, 1);
    check("end_sframe", which ? sf1 : sf0, 0);
    @(negedge clk);
    check("after_done", which ? dn1 : dn0, 0);
  endtask

  initial begin
    rst = 1'b1;
    lv0 = 1'b0; ld0 = '0;
    lv1 = 1'b0; ld1 = '0;
    #2;
    check("rst_ready",  rdy0, 1);
    check("rst_sd",     sd0, 0);
    check("rst_sframe", sf0, 0);
    check("rst_done",   dn0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle window with no requests.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_ready",  rdy0, 1);
      check("idle_sframe", sf0, 0);
      check("idle_done",   dn0, 0);
      check("idle_ready1", rdy1, 1);
    end

    // Plain frame, then a parity frame.
    send(1'b0, 8'hA5);
    expect_frame(1'b0);
    check("q0_drained_a5", q0.size(), 0);

    send(1'b1, 8'h07);
    expect_frame(1'b1);
    check("q1_drained_07", q1.size(), 0);

    // Back-to-back frames with load_valid held high.
    push_word(1'b0, 8'hFF);
    push_word(1'b0, 8'hFF);
    push_word(1'b0, 8'hFF);
    lv0 = 1'b1; ld0 = 8'hFF;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < FLEN0; i++) begin
        @(negedge clk);
        check("b2b_sframe", sf0, 1);
        if (f == 2 && i == 0) lv0 = 1'b0;
      end
      @(negedge clk);
      check("b2b_gap_sframe", sf0, 0);
      check("b2b_gap_done",   dn0, 1);
    end
    @(negedge clk);
    check("b2b_end_sframe", sf0, 0);
    check("b2b_end_done",   dn0, 0);
    check("q0_drained_ff",  q0.size(), 0);

    // Requests during SHIFT must be ignored.
    send(1'b0, 8'hA5);
    for (int i = 0; i < FLEN0; i++) begin
      @(negedge clk);
      check("ign_sframe", sf0, 1);
      check("ign_ready",  rdy0, 0);
      if (i >= 2 && i <= 4) begin lv0 = 1'b1; ld0 = 8'h3C; end
      else lv0 = 1'b0;
    end
    @(negedge clk);
    check("ign_done", dn0, 1);
    @(negedge clk);
    check("ign_no_frame", sf0, 0);
    check("q0_drained_ign", q0.size(), 0);

    // Asynchronous reset in the middle of a frame.
    send(1'b0, 8'hA5);
    repeat (3) @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_sd",     sd0, 0);
    check("abort_sframe", sf0, 0);
    check("abort_done",   dn0, 0);
    check("abort_ready",  rdy0, 1);
    q0.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_done",   dn0, 0);
      check("post_abort_sframe", sf0, 0);
    end
    send(1'b0, 8'hA5);
    expect_frame(1'b0);

    check("q0_final", q0.size(), 0);
    check("q1_final", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
